// File: rtl/fb_write_queue.sv
// CPU-to-framebuffer write queue: buffers bus writes, issues them only in CPU slot cycles,
// and runs an in-order constant-byte block fill (screen clear, line erase).
module fb_write_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 14,
  parameter int FB_TOP = 16384
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              slot,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [7:0]        fill_value,
  output logic              fill_busy,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              fb_wren,
  output logic              empty,
  output logic              overflow,
  input  logic              overflow_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, FILL_WAIT, FILL} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [7:0]        r_mem_data [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic [CW-1:0]     r_snap, w_snap_nxt;
  logic [ADDR_W-1:0] r_faddr, r_flen;
  logic [7:0]        r_fval;
  logic              r_fill_busy, r_ovf;
  logic [ADDR_W-1:0] r_last_addr;
  logic [7:0]        r_last_data;

  logic              w_push, w_drop, w_pop, w_drain, w_fill_go, w_last_fill, w_fill_acc, w_wren;
  logic [ADDR_W-1:0] w_fill_addr_mod, w_faddr_inc, w_iss_addr;
  logic [7:0]        w_iss_data;

  assign wr_ready  = (r_count != CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign fill_busy = r_fill_busy;
  assign overflow  = r_ovf;

  assign w_push      = wr_req && wr_ready;
  assign w_drop      = wr_req && !wr_ready;
  // FILL_WAIT drains the entries queued ahead of a pending fill, exactly like DRAIN.
  assign w_drain     = ((r_state == DRAIN) || (r_state == FILL_WAIT)) && !empty;
  assign w_pop       = slot && w_drain;
  assign w_fill_go   = slot && (r_state == FILL);
  assign w_last_fill = w_fill_go && (r_flen == ADDR_W'(1));
  assign w_wren      = w_pop || w_fill_go;
  assign w_fill_acc  = fill_start && !r_fill_busy && (fill_len != '0);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  assign w_fill_addr_mod = ADDR_W'(int'(fill_addr) % FB_TOP);
  assign w_faddr_inc     = (r_faddr == ADDR_W'(FB_TOP - 1)) ? '0 : r_faddr + ADDR_W'(1);

  assign w_iss_addr = (r_state == FILL) ? r_faddr : r_mem_addr[r_rptr];
  assign w_iss_data = (r_state == FILL) ? r_fval  : r_mem_data[r_rptr];
  assign fb_wren    = w_wren;
  assign fb_addr    = w_wren ? w_iss_addr : r_last_addr;
  assign fb_data    = w_wren ? w_iss_data : r_last_data;

  always_comb begin
    w_state_nxt = r_state;
    w_snap_nxt  = r_snap;
    case (r_state)
      IDLE: begin
        if (w_fill_acc) begin
          w_snap_nxt  = r_count;
          w_state_nxt = (r_count == '0) ? FILL : FILL_WAIT;
        end else if (w_count_nxt != '0) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_fill_acc) begin
          // entries present before this edge (minus any popping now) go ahead of the fill
          w_snap_nxt  = r_count - CW'(w_pop);
          w_state_nxt = (w_snap_nxt == '0) ? FILL : FILL_WAIT;
        end else if (w_count_nxt == '0) begin
          w_state_nxt = IDLE;
        end
      end
      FILL_WAIT: begin
        if (w_pop) begin
          w_snap_nxt = r_snap - CW'(1);
          if (r_snap == CW'(1)) w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (w_last_fill) w_state_nxt = (w_count_nxt != '0) ? DRAIN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr] <= wr_addr;
      r_mem_data[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_snap      <= '0;
      r_faddr     <= '0;
      r_flen      <= '0;
      r_fval      <= '0;
      r_fill_busy <= 1'b0;
      r_ovf       <= 1'b0;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_snap  <= w_snap_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_drop)            r_ovf <= 1'b1;
      else if (overflow_clr) r_ovf <= 1'b0;
      if (w_wren) begin
        r_last_addr <= w_iss_addr;
        r_last_data <= w_iss_data;
      end
      if (w_fill_acc) begin
        r_faddr     <= w_fill_addr_mod;
        r_flen      <= fill_len;
        r_fval      <= fill_value;
        r_fill_busy <= 1'b1;
      end else if (w_fill_go) begin
        r_faddr <= w_faddr_inc;
        r_flen  <= r_flen - ADDR_W'(1);
        if (w_last_fill) r_fill_busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fb_write_queue.sv
// Randomized and directed bench for fb_write_queue against a job-list model of the write stream.
module tb_fb_write_queue;
  localparam int DEPTH = 8, ADDR_W = 14, FB_TOP = 16384;

  logic clk = 1'b0;
  logic resetb, slot, wr_req, fill_start, overflow_clr;
  logic [ADDR_W-1:0] wr_addr, fill_addr, fill_len, fb_addr;
  logic [7:0] wr_data, fill_value, fb_data;
  logic wr_ready, fill_busy, fb_wren, empty, overflow;

  fb_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FB_TOP(FB_TOP)) dut (
    .clk(clk), .resetb(resetb), .slot(slot),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .fill_start(fill_start), .fill_addr(fill_addr), .fill_len(fill_len),
    .fill_value(fill_value), .fill_busy(fill_busy),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_wren(fb_wren),
    .empty(empty), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // Pending work in issue order: single writes and fills (fill addr advances as bytes go out).
  typedef struct {bit is_fill; int addr; int data; int len;} job_t;
  job_t jobs[$];
  int m_ovf, last_addr, last_data, n_wr;
  int n_tests, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int n_writes();
    int n = 0;
    foreach (jobs[i]) if (!jobs[i].is_fill) n++;
    return n;
  endfunction

  function automatic bit m_busy();
    foreach (jobs[i]) if (jobs[i].is_fill) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc(input bit s, input bit wq, input int wa, input int wd,
                     input bit fs, input int fa, input int fl, input int fv, input bit oc);
    bit ew, rdy, bsy;
    int ea, ed;
    wa &= 16383; fa &= 16383; fl &= 16383; wd &= 255; fv &= 255;
    slot = s; wr_req = wq; wr_addr = ADDR_W'(wa); wr_data = 8'(wd);
    fill_start = fs; fill_addr = ADDR_W'(fa); fill_len = ADDR_W'(fl); fill_value = 8'(fv);
    overflow_clr = oc;
    @(negedge clk);
    ew = s && (jobs.size() > 0);
    ea = last_addr; ed = last_data;
    if (ew) begin ea = jobs[0].addr; ed = jobs[0].data; end
    chk("wren", fb_wren, ew);
    chk("fb_addr", fb_addr, ea);
    chk("fb_data", fb_data, ed);
    chk("wr_ready", wr_ready, n_writes() != DEPTH);
    chk("empty", empty, n_writes() == 0);
    chk("fill_busy", fill_busy, m_busy());
    chk("overflow", overflow, m_ovf);
    rdy = (n_writes() != DEPTH);
    bsy = m_busy();
    if (ew) begin
      last_addr = ea; last_data = ed; n_wr++;
      if (jobs[0].is_fill) begin
        jobs[0].addr = (jobs[0].addr + 1) % FB_TOP;
        jobs[0].len  = jobs[0].len - 1;
        if (jobs[0].len == 0) void'(jobs.pop_front());
      end else void'(jobs.pop_front());
    end
    if (fs && !bsy && fl != 0) jobs.push_back('{1'b1, fa % FB_TOP, fv, fl});
    if (wq && rdy) jobs.push_back('{1'b0, wa, wd, 0});
    if (wq && !rdy) m_ovf = 1;
    else if (oc) m_ovf = 0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit alt);
    for (int i = 0; i < n; i++) cyc(alt ? bit'(i % 2) : 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int base;
    n_tests = 0; n_fail = 0; n_wr = 0; m_ovf = 0; last_addr = 0; last_data = 0;
    resetb = 1'b0; slot = 1'b1; wr_req = 0; wr_addr = '0; wr_data = '0;
    fill_start = 0; fill_addr = '0; fill_len = '0; fill_value = '0; overflow_clr = 0;
    #3;
    chk("rst_wren", fb_wren, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_busy", fill_busy, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk); #1 resetb = 1'b1;

    // three writes under alternating slot
    cyc(0, 1, 'h10, 'hAA, 0, 0, 0, 0, 0);
    cyc(1, 1, 'h11, 'hBB, 0, 0, 0, 0, 0);
    cyc(0, 1, 'h12, 'hCC, 0, 0, 0, 0, 0);
    idle(10, 1);
    chk("t1_writes", n_wr, 3);

    // fill the FIFO with slot low, drop the 9th, clear, then drain
    for (int i = 0; i < 9; i++) cyc(0, 1, 'h100 + i, i * 7, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_ovf_set", overflow, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    base = n_wr;
    idle(24, 1);
    chk("t2_drained", n_wr - base, 8);

    // fill wrapping past the top of the framebuffer
    base = n_wr;
    cyc(1, 0, 0, 0, 1, 'h3FFE, 4, 'h20, 0);
    idle(6, 0);
    chk("t3_fill", n_wr - base, 4);
    chk("t3_last", last_addr, 1);

    // two writes, fill, one write: model enforces the order
    cyc(0, 1, 'h200, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 'h201, 2, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 'h300, 3, 'h55, 0);
    cyc(0, 1, 'h202, 3, 0, 0, 0, 0, 0);
    base = n_wr;
    idle(16, 1);
    chk("t4_count", n_wr - base, 6);
    chk("t4_last", last_addr, 'h202);

    // zero-length fill and fill during busy are ignored
    cyc(1, 0, 0, 0, 1, 'h400, 0, 'h11, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_len0", fill_busy, 0);
    base = n_wr;
    cyc(0, 0, 0, 0, 1, 'h500, 5, 'h66, 0);
    cyc(1, 0, 0, 0, 1, 'h600, 7, 'h77, 0);
    idle(10, 0);
    chk("t5_only_first", n_wr - base, 5);

    // reset in the middle of a fill with 4 writes queued behind it
    cyc(0, 0, 0, 0, 1, 'h700, 20, 'h99, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 'h800 + i, i, 0, 0, 0, 0, 0);
    idle(3, 0);
    slot = 1'b1; resetb = 1'b0;
    #1;
    chk("rst_mid_wren", fb_wren, 0);
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_busy", fill_busy, 0);
    jobs.delete(); m_ovf = 0; last_addr = 0; last_data = 0;
    #2 resetb = 1'b1;
    base = n_wr;
    idle(12, 0);
    chk("rst_no_writes", n_wr - base, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit s, wq, fs, oc;
      int fl;
      s  = (i % 1000 < 300) ? ($urandom_range(0, 3) == 0) : bit'($urandom_range(0, 1));
      wq = ($urandom_range(0, 9) < 4);
      fs = ($urandom_range(0, 39) == 0);
      fl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
      oc = ($urandom_range(0, 19) == 0);
      cyc(s, wq, $urandom, $urandom, fs, $urandom, fl, $urandom, oc);
    end
    idle(300, 0);
    chk("final_empty", empty, 1);
    chk("final_busy", fill_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
